// File: rtl/zrb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// zrb_uart_tx_arbiter
//
// Purpose: round-robin packet arbiter sharing one UART transmit write port
// among NUM_REQ byte-stream requesters. A grant is held for a whole packet.
// Each packet optionally starts with a header byte (ID_BASE + requester
// index), and its payload is cut off after MAX_LEN bytes.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req        in   per-requester byte valid / packet in progress
//   data       in   flattened payload bytes, requester i at data[8*i +: 8]
//   last       in   per-requester "current byte is the final one"
//   ack        out  one-hot, byte of the granted requester consumed
//   grant      out  one-hot registered owner, 0 when idle
//   tx_en      in   UART TX FIFO can accept a byte
//   wr         out  write strobe to the UART TX FIFO
//   data_out   out  byte to the UART TX FIFO (valid with wr)
//   busy       out  a packet is being handled
//   forced_end out  1-cycle pulse after a packet is cut at MAX_LEN
// ---------------------------------------------------------------------------
module zrb_uart_tx_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter bit          HDR_EN  = 1'b1,
  parameter logic [7:0]  ID_BASE = 8'hA0,
  parameter int          MAX_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  input  logic [NUM_REQ-1:0]   last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 tx_en,
  output logic                 wr,
  output logic [7:0]           data_out,
  output logic                 busy,
  output logic                 forced_end
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               fe_q, fe_d;

  logic [IDX_W-1:0]   sel;
  logic               sel_vld;
  logic               req_g;
  logic               last_g;
  logic [7:0]         data_g;
  logic [8:0]         cnt_inc;
  logic               hit_max;
  logic               pay_wr;

  // Round-robin pick: scan from ptr+1 upward (cyclically). The loop runs
  // from the lowest priority to the highest so the highest-priority asserted
  // requester is the last assignment and wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(ptr_q) + k) % NUM_REQ]) begin
        sel     = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
        sel_vld = 1'b1;
      end
    end
  end

  assign req_g   = req[gidx_q];
  assign last_g  = last[gidx_q];
  assign data_g  = data[{gidx_q, 3'b000} +: 8];
  // Nine bits so that byte_cnt+1 is compared without wrapping.
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign hit_max = (cnt_inc == 9'(MAX_LEN));
  assign pay_wr  = (state_q == ST_PAYLOAD) && tx_en && req_g;

  // Write-side outputs are combinational on tx_en/req so the FIFO captures
  // the byte on the same edge that the requester sees its ack.
  always_comb begin
    wr       = 1'b0;
    ack      = '0;
    data_out = 8'h00;
    case (state_q)
      ST_HEADER: begin
        wr       = tx_en;
        data_out = ID_BASE + {{(8-IDX_W){1'b0}}, gidx_q};
      end
      ST_PAYLOAD: begin
        wr       = pay_wr;
        data_out = data_g;
        ack      = grant_q & {NUM_REQ{pay_wr}};
      end
      default: ;
    endcase
  end

  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign forced_end = fe_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fe_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          grant_d = NUM_REQ'(1) << sel;
          gidx_d  = sel;
          cnt_d   = 8'd0;
          state_d = HDR_EN ? ST_HEADER : ST_PAYLOAD;
        end
      end
      ST_HEADER: begin
        // Header goes out even if the requester has already dropped req.
        if (tx_en) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (!req_g) begin
          // Requester withdrew: abandon the packet without writing.
          state_d = ST_IDLE;
          ptr_d   = gidx_q;
          grant_d = '0;
        end else if (tx_en) begin
          cnt_d = cnt_inc[7:0];
          if (last_g || hit_max) begin
            state_d = ST_IDLE;
            ptr_d   = gidx_q;
            grant_d = '0;
            fe_d    = !last_g;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= 8'd0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fe_q    <= fe_d;
    end
  end

endmodule

// File: tb/tb_zrb_uart_tx_arbiter.sv
module tb_zrb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int MAXL = 4;
  localparam logic [7:0] IDB = 8'hA0;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] data = '0;
  logic [NREQ-1:0]   last = '0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              tx_en = 1'b0;
  logic              wr;
  logic [7:0]        data_out;
  logic              busy;
  logic              forced_end;

  zrb_uart_tx_arbiter #(
    .NUM_REQ(NREQ), .HDR_EN(1'b1), .ID_BASE(IDB), .MAX_LEN(MAXL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .data(data), .last(last),
    .ack(ack), .grant(grant), .tx_en(tx_en), .wr(wr), .data_out(data_out),
    .busy(busy), .forced_end(forced_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester byte queues: bit 8 = last flag, bits 7:0 = byte.
  logic [8:0]      rq [NREQ][$];
  logic [NREQ-1:0] ack_seen = '0;
  logic [7:0]      wlog [$];
  logic [7:0]      eq [$];
  int              fe_cnt = 0;

  // Requesters: present the head of their queue, pop it after an ack.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        req[i]          = 1'b1;
        last[i]         = rq[i][0][8];
        data[8*i +: 8]  = rq[i][0][7:0];
      end else begin
        req[i]          = 1'b0;
        last[i]         = 1'b0;
        data[8*i +: 8]  = 8'h00;
      end
    end
  end

  // Behavioural model: who owns the path, whether its header is still owed,
  // how many payload bytes it has sent, and who was served last.
  int m_owner = -1;
  bit m_hdr   = 1'b0;
  int m_cnt   = 0;
  int m_ptr   = NREQ - 1;
  bit m_fe    = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1; m_hdr = 1'b0; m_cnt = 0; m_ptr = NREQ - 1; m_fe = 1'b0;
    end else begin
      bit fe;
      fe = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            m_hdr   = 1'b1;
            m_cnt   = 0;
          end
        end
      end else if (m_hdr) begin
        if (tx_en) m_hdr = 1'b0;
      end else if (!req[m_owner]) begin
        m_ptr = m_owner; m_owner = -1;
      end else if (tx_en) begin
        m_cnt++;
        if (last[m_owner] || m_cnt == MAXL) begin
          fe = !last[m_owner];
          m_ptr = m_owner; m_owner = -1;
        end
      end
      m_fe = fe;
    end
  end

  // Compare every cycle mid-period, and log what the FIFO would capture.
  always @(negedge clk) begin
    logic [NREQ-1:0] e_grant, e_ack;
    logic e_busy, e_wr;
    logic [7:0] e_data;
    e_grant = '0; e_ack = '0; e_busy = 1'b0; e_wr = 1'b0; e_data = 8'h00;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_busy = 1'b1;
      if (m_hdr) begin
        e_wr   = tx_en;
        e_data = IDB + 8'(m_owner);
      end else begin
        e_wr   = tx_en & req[m_owner];
        e_data = data[8*m_owner +: 8];
        e_ack[m_owner] = e_wr;
      end
    end
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("wr", 32'(wr), 32'(e_wr));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("data_out", 32'(data_out), 32'(e_data));
    chk("forced_end", 32'(forced_end), 32'(m_fe));
    ack_seen = ack;
    if (wr) wlog.push_back(data_out);
    if (forced_end) fe_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, 32'(wlog.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size(); i++)
      if (i < wlog.size()) chk(nm, 32'(wlog[i]), 32'(eq[i]));
    wlog.delete();
  endtask

  task automatic push(input int r, input logic lst, input logic [7:0] b);
    rq[r].push_back({lst, b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr", 32'(wr), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    tx_en   = 1'b1;
    reset_n = 1'b1;

    // Single requester, two-byte packet.
    push(0, 1'b0, 8'h11); push(0, 1'b1, 8'h22);
    repeat (10) step();
    eq = '{8'hA0, 8'h11, 8'h22};
    check_log("t1_single");

    // Round-robin from a fresh reset: requester 0 goes first.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    push(0, 1'b1, 8'hB0); push(0, 1'b1, 8'hB4);
    push(1, 1'b1, 8'hB1); push(2, 1'b1, 8'hB2); push(3, 1'b1, 8'hB3);
    repeat (22) step();
    eq = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3, 8'hA0, 8'hB4};
    check_log("t2_rr");

    // Backpressure for 3 cycles after the first payload byte.
    push(1, 1'b0, 8'h31); push(1, 1'b0, 8'h32); push(1, 1'b1, 8'h33);
    repeat (4) step();
    tx_en = 1'b0;
    step();
    chk("t3_stall_wr", 32'(wr), 32'h0);
    chk("t3_stall_ack", 32'(ack), 32'h0);
    chk("t3_stall_data", 32'(data_out), 32'h32);
    repeat (2) step();
    tx_en = 1'b1;
    repeat (8) step();
    eq = '{8'hA1, 8'h31, 8'h32, 8'h33};
    check_log("t3_bp");

    // MAX_LEN cut-off, then requester 3 goes before the leftover of 2,
    // whose remainder ends in an abort when its queue runs dry.
    fe_cnt = 0;
    for (int i = 0; i < 6; i++) push(2, 1'b0, 8'h41 + 8'(i));
    push(3, 1'b1, 8'h51);
    repeat (22) step();
    eq = '{8'hA2, 8'h41, 8'h42, 8'h43, 8'h44, 8'hA3, 8'h51, 8'hA2, 8'h45, 8'h46};
    check_log("t4_maxlen");
    chk("t4_fe_count", 32'(fe_cnt), 32'd1);

    // Abort by requester 1 after two bytes; it then becomes lowest priority.
    fe_cnt = 0;
    push(1, 1'b0, 8'h61); push(1, 1'b0, 8'h62);
    repeat (10) step();
    eq = '{8'hA1, 8'h61, 8'h62};
    check_log("t5_abort");
    chk("t5_fe_count", 32'(fe_cnt), 32'd0);
    push(1, 1'b1, 8'h71); push(2, 1'b1, 8'h72);
    repeat (10) step();
    eq = '{8'hA2, 8'h72, 8'hA1, 8'h71};
    check_log("t5_ptr");

    // Asynchronous reset in the middle of a payload.
    push(2, 1'b0, 8'h81); push(2, 1'b0, 8'h82); push(2, 1'b1, 8'h83);
    repeat (4) step();
    chk("t6_pre_grant", 32'(grant), 32'h4);
    chk("t6_pre_wr", 32'(wr), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wr", 32'(wr), 32'h0);
    chk("t6_rst_ack", 32'(ack), 32'h0);
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_data", 32'(data_out), 32'h0);
    eq = '{8'hA2, 8'h81};
    check_log("t6_partial");
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    repeat (2) step();
    reset_n = 1'b1;
    push(3, 1'b1, 8'h93); push(0, 1'b1, 8'h90);
    repeat (10) step();
    eq = '{8'hA0, 8'h90, 8'hA3, 8'h93};
    check_log("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zrb_uart_tx_arbiter.md
Name: zrb_uart_tx_arbiter

Overview:
Round-robin packet arbiter that shares one UART transmit path among NUM_REQ byte-stream requesters. It sits in front of zrb_uart_top's transmit side and drives its wr/data_in write port, qualified by tx_en (TX FIFO not full). A grant is held for a whole packet. Each packet is optionally prefixed with a header byte identifying the requester. Packet length is capped at MAX_LEN payload bytes.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
HDR_EN, 1, 1 = emit header byte ID_BASE+index before the payload; 0 = no header.
ID_BASE, 8'hA0, header byte base value; header = ID_BASE + requester index, modulo 256.
MAX_LEN, 16, maximum payload bytes per packet; legal range 1..255.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
req  in  NUM_REQ  per-requester "byte valid / packet in progress".
data  in  8*NUM_REQ  flattened payload bytes; requester i uses data[8*i+7:8*i].
last  in  NUM_REQ  per-requester "current byte is final byte of packet".
ack  out  NUM_REQ  one-hot; byte from requester i consumed this cycle.
grant  out  NUM_REQ  one-hot registered owner of the UART path; 0 when idle.
tx_en  in  1  UART TX FIFO can accept a byte (tx_en = ~tx_full).
wr  out  1  write strobe to the UART TX FIFO.
data_out  out  8  byte to the UART TX FIFO; valid when wr=1.
busy  out  1  1 while a packet is being handled (state != IDLE).
forced_end  out  1  1-cycle pulse when a packet is cut off at MAX_LEN without last.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant=0, ptr=NUM_REQ-1 (requester 0 has highest priority first), byte_cnt=0, forced_end=0. While in reset, wr=0, ack=0, data_out=0, busy=0.
- States are IDLE, HEADER, and PAYLOAD.
- IDLE:
  - If req!=0, select the first asserted requester searching cyclically from ptr+1.
  - Register grant=onehot(sel) and byte_cnt=0.
  - Next state is HEADER if HDR_EN, else PAYLOAD.
  - Grant appears 1 cycle after req. No byte is written in IDLE.
- HEADER:
  - wr = tx_en; data_out = ID_BASE+sel; ack=0.
  - If tx_en, go to PAYLOAD; otherwise hold in HEADER.
  - The header is sent even if req[sel] has dropped.
- PAYLOAD (g = granted index):
  - wr = tx_en & req[g]; data_out = data[g]; ack[g] = wr.
  - wr, ack and data_out are combinational (same-cycle) on tx_en/req; the FIFO captures on the same edge.
  - On wr: byte_cnt increments.
  - If last[g] or byte_cnt+1 == MAX_LEN: go to IDLE, ptr=g, grant=0.
  - forced_end pulses the following cycle iff MAX_LEN was reached with last[g]=0.
  - If req[g]=0 (regardless of tx_en): abort. Go to IDLE, ptr=g, grant=0, no write, no forced_end.
  - If tx_en=0 and req[g]=1: stall; hold all state, no ack.
- Outside PAYLOAD, data_out=0 except in HEADER.
- Minimum gap: at least one IDLE cycle between packets. Back-to-back packets from different requesters are separated by exactly 1 cycle when tx_en=1.
- Fairness: the requester just served becomes lowest priority. No requester waits more than NUM_REQ-1 packets.
- Timing/ignore rules:
  - req/last/data of non-granted requesters are ignored.
  - ack is never asserted to a non-granted requester.
  - ack is at most one-hot.
- Reset mid-packet: immediate return to IDLE. A partial packet already in the FIFO is not retracted.
- Width rules:
  - byte_cnt is 8 bits.
  - Header addition wraps modulo 256.
  - The sel index is $clog2(NUM_REQ) bits wide.

Test Plan:
- Reset then single requester: req[0]=1, data0=8'h11,8'h22 (last on 2nd), tx_en=1, HDR_EN=1 -> grant=0001 next cycle; wr bytes A0,11,22 on consecutive cycles; ack[0] on 11 and 22; busy falls after 22.
- Round-robin: req=1111 held, each requester sends 1-byte packets (last=1) -> header order A0,A1,A2,A3,A0; one idle cycle between packets.
- Backpressure: tx_en=0 for 3 cycles mid-payload -> wr=0 and ack=0 during those cycles, data_out stable; resumes with no byte lost or duplicated.
- MAX_LEN=4, requester 2 streams 6 bytes without last -> 4 payload bytes written after A2; forced_end pulses once; grant then drops; requester 2 loses priority to a pending requester 3.
- Abort: req[1] drops after 2 payload bytes -> return to IDLE, no further wr, forced_end=0, ptr=1.
- Async reset asserted mid-PAYLOAD -> wr, ack, grant and busy go 0 immediately without a clock edge; next arbitration starts from requester 0.
